// File: rtl/simon_sequencer.sv
// simon_sequencer: game sequencer driving a 4-bit LFSR (step / rerun / randomize).
// The colour sequence is never stored: rewinding the LFSR to its captured seed
// and stepping N times regenerates the same N colours.
// Optional feature macro: SIMON_TIMEOUT_EN adds a per-press timeout in WAIT_IN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | after reset, LFSR free-running, waiting for start
// SEED      | two cycles while the LFSR captures its seed
// REWIND_P  | rerun pulse, then dark gap before playback
// SHOW_ON   | current colour lit
// SHOW_OFF  | dark gap after a lit colour; steps to the next element
// REWIND_I  | rerun pulse so input checking starts at element 0
// WAIT_IN   | waiting for the player's presses, button echo on led
// NEXT      | level complete: grow the sequence or declare a win
// WIN       | whole sequence reproduced, LFSR free-running
// LOSE      | wrong press (or timeout), LFSR free-running
module simon_sequencer #(
  parameter int MAX_LEN = 32,
  parameter int ON_CYC  = 25_000_000,
  parameter int OFF_CYC = 12_000_000,
  parameter int TMO_CYC = 150_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [3:0] i_random,
  input  logic [3:0] i_btn,
  output logic       o_lfsr_step,
  output logic       o_lfsr_rerun,
  output logic       o_lfsr_randomize,
  output logic [3:0] o_led,
  output logic [5:0] o_level,
  output logic       o_busy,
  output logic       o_win,
  output logic       o_lose
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SEED     = 4'd1,
    ST_REWIND_P = 4'd2,
    ST_SHOW_ON  = 4'd3,
    ST_SHOW_OFF = 4'd4,
    ST_REWIND_I = 4'd5,
    ST_WAIT_IN  = 4'd6,
    ST_NEXT     = 4'd7,
    ST_WIN      = 4'd8,
    ST_LOSE     = 4'd9
  } state_t;

  // One shared down-counter covers every timed state.
  localparam int ON_OFF_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
`ifdef SIMON_TIMEOUT_EN
  localparam int CNT_MAX = (TMO_CYC > ON_OFF_MAX) ? TMO_CYC : ON_OFF_MAX;
`else
  localparam int CNT_MAX = ON_OFF_MAX;
  localparam int unused_tmo_cyc = TMO_CYC;
`endif
  localparam int CW = $clog2(CNT_MAX) + 1;

  // SEED lasts two cycles; REWIND_P is the rerun cycle plus OFF_CYC dark cycles.
  localparam logic [CW-1:0] LD_SEED = CW'(1);
  localparam logic [CW-1:0] LD_GAP  = CW'(OFF_CYC);
  localparam logic [CW-1:0] LD_ON   = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] LD_OFF  = CW'(OFF_CYC - 1);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [CW-1:0] LD_TMO  = CW'(TMO_CYC - 1);
`endif
  localparam logic [5:0] LEVEL_MAX = 6'(MAX_LEN);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [5:0]    r_idx;
  logic [5:0]    w_idx_nxt;
  logic [5:0]    r_level;
  logic [5:0]    w_level_nxt;
  logic [3:0]    r_echo;

  logic          w_step;
  logic          w_rerun;
  logic          w_cnt_done;
  logic          w_last;
  logic          w_idle;
  logic [3:0]    w_colour;
  logic          w_unused_random;

  assign w_cnt_done      = (r_cnt == '0);
  assign w_last          = (r_idx == (r_level - 6'd1));
  assign w_colour        = 4'b0001 << i_random[1:0];
  assign w_unused_random = ^i_random[3:2];
  assign w_idle          = (r_state == ST_IDLE) || (r_state == ST_WIN) ||
                           (r_state == ST_LOSE);

  // State, counter, index, level and button-echo registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_level <= '0;
      r_echo  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_level <= w_level_nxt;
      r_echo  <= (r_state == ST_WAIT_IN) ? i_btn : 4'b0000;
    end
  end

  // Next-state, counter reloads and LFSR pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_level_nxt = r_level;
    w_step      = 1'b0;
    w_rerun     = 1'b0;
    case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        w_cnt_nxt = '0;
        if (i_start) begin
          w_state_nxt = ST_SEED;
          w_cnt_nxt   = LD_SEED;
          w_idx_nxt   = '0;
          w_level_nxt = 6'd1;
        end
      end
      ST_SEED: begin
        if (w_cnt_done) begin
          w_state_nxt = ST_REWIND_P;
          w_cnt_nxt   = LD_GAP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_REWIND_P: begin
        // Rerun only on the entry cycle; the rest of the state is dark gap.
        w_rerun   = (r_cnt == LD_GAP);
        w_idx_nxt = '0;
        if (w_cnt_done) begin
          w_state_nxt = ST_SHOW_ON;
          w_cnt_nxt   = LD_ON;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_SHOW_ON: begin
        if (w_cnt_done) begin
          w_state_nxt = ST_SHOW_OFF;
          w_cnt_nxt   = LD_OFF;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_SHOW_OFF: begin
        if (w_cnt_done) begin
          if (w_last) begin
            w_state_nxt = ST_REWIND_I;
          end else begin
            w_step      = 1'b1;
            w_idx_nxt   = r_idx + 6'd1;
            w_state_nxt = ST_SHOW_ON;
            w_cnt_nxt   = LD_ON;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_REWIND_I: begin
        w_rerun     = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = ST_WAIT_IN;
`ifdef SIMON_TIMEOUT_EN
        w_cnt_nxt   = LD_TMO;
`else
        w_cnt_nxt   = '0;
`endif
      end
      ST_WAIT_IN: begin
        if (i_btn == w_colour) begin
          if (w_last) begin
            w_state_nxt = ST_NEXT;
          end else begin
            w_step    = 1'b1;
            w_idx_nxt = r_idx + 6'd1;
`ifdef SIMON_TIMEOUT_EN
            w_cnt_nxt = LD_TMO;
`endif
          end
        end else if (i_btn != 4'b0000) begin
          w_state_nxt = ST_LOSE;
`ifdef SIMON_TIMEOUT_EN
        end else if (w_cnt_done) begin
          w_state_nxt = ST_LOSE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
`endif
        end
      end
      ST_NEXT: begin
        if (r_level == LEVEL_MAX) begin
          w_state_nxt = ST_WIN;
        end else begin
          // Stepping past the last element appends the new colour.
          w_level_nxt = r_level + 6'd1;
          w_step      = 1'b1;
          w_state_nxt = ST_REWIND_P;
          w_cnt_nxt   = LD_GAP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_lfsr_step      = w_step;
  assign o_lfsr_rerun     = w_rerun;
  assign o_lfsr_randomize = w_idle;
  assign o_busy           = ~w_idle;
  assign o_win            = (r_state == ST_WIN);
  assign o_lose           = (r_state == ST_LOSE);
  assign o_led            = (r_state == ST_SHOW_ON) ? w_colour : r_echo;
  assign o_level          = r_level;

endmodule
